// File: rtl/wb_dcache_nway_controller.sv
// Control FSM for an N-way set-associative write-back data cache: hit/miss handling,
// victim selection (invalid-first, then per-set round-robin) and a full dirty-line flush sweep.
module wb_dcache_nway_controller #(
  parameter  int NUM_WAYS = 4,
  parameter  int NUM_SETS = 128,
  localparam int WAY_BITS = $clog2(NUM_WAYS),
  localparam int IDX_BITS = $clog2(NUM_SETS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                lsummu2dcache_req_i,
  input  logic                lsummu2dcache_wr_i,
  output logic                dcache2lsummu_ack_o,
  input  logic                dcache_flush_i,
  input  logic                dmem_sel_i,
  input  logic [IDX_BITS-1:0] req_idx_i,
  input  logic [NUM_WAYS-1:0] way_hit_i,
  input  logic [NUM_WAYS-1:0] way_valid_i,
  input  logic [NUM_WAYS-1:0] way_dirty_i,
  output logic [WAY_BITS-1:0] way_sel_o,
  output logic                cache_wr_o,
  output logic                cache_line_wr_o,
  output logic                cache_line_clean_o,
  output logic                cache_wrb_req_o,
  output logic                flush_active_o,
  output logic [IDX_BITS-1:0] evict_index_o,
  output logic                dcache2mem_req_o,
  output logic                dcache2mem_wr_o,
  input  logic                mem2dcache_ack_i
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    ALLOCATE,
    WRITE_BACK,
    FLUSH,
    FLUSH_WB
  } state_e;

  state_e              state_q, state_d;
  logic [WAY_BITS-1:0] victim_q, victim_d;
  logic [IDX_BITS-1:0] evict_idx_q, evict_idx_d;
  logic [WAY_BITS-1:0] flush_way_q, flush_way_d;
  logic [WAY_BITS-1:0] rr_q [NUM_SETS];
  logic                rr_inc;

  logic [WAY_BITS-1:0] hit_way;
  logic                hit_any;
  logic [WAY_BITS-1:0] victim_sel;
  logic                victim_dirty;
  logic                flush_line_dirty;
  logic                last_line;
  logic [IDX_BITS-1:0] adv_idx;
  logic [WAY_BITS-1:0] adv_way;

  // Lowest matching way wins; victim is the lowest invalid way, else the set's rr pointer.
  always_comb begin
    hit_way    = '0;
    victim_sel = rr_q[req_idx_i];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (way_hit_i[w]) hit_way = WAY_BITS'(w);
    end
    if (!(&way_valid_i)) begin
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
        if (!way_valid_i[w]) victim_sel = WAY_BITS'(w);
      end
    end
  end

  assign hit_any          = |way_hit_i;
  assign victim_dirty     = way_valid_i[victim_sel] & way_dirty_i[victim_sel];
  assign flush_line_dirty = way_valid_i[flush_way_q] & way_dirty_i[flush_way_q];
  assign last_line        = (evict_idx_q == IDX_BITS'(NUM_SETS - 1)) &&
                            (flush_way_q == WAY_BITS'(NUM_WAYS - 1));
  assign adv_way          = flush_way_q + WAY_BITS'(1);
  assign adv_idx          = (flush_way_q == WAY_BITS'(NUM_WAYS - 1)) ?
                            evict_idx_q + IDX_BITS'(1) : evict_idx_q;
  assign evict_index_o    = evict_idx_q;

  // Outputs are gated by rst_ni so an asserted reset silences the bus immediately.
  always_comb begin
    state_d             = state_q;
    victim_d            = victim_q;
    evict_idx_d         = evict_idx_q;
    flush_way_d         = flush_way_q;
    rr_inc              = 1'b0;
    dcache2lsummu_ack_o = 1'b0;
    way_sel_o           = '0;
    cache_wr_o          = 1'b0;
    cache_line_wr_o     = 1'b0;
    cache_line_clean_o  = 1'b0;
    cache_wrb_req_o     = 1'b0;
    flush_active_o      = 1'b0;
    dcache2mem_req_o    = 1'b0;
    dcache2mem_wr_o     = 1'b0;
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          if (dcache_flush_i) begin
            state_d = FLUSH;
          end else if (lsummu2dcache_req_i && dmem_sel_i) begin
            if (hit_any) begin
              way_sel_o = hit_way;
              if (lsummu2dcache_wr_i) begin
                cache_wr_o = 1'b1;
                state_d    = WRITE;
              end else begin
                state_d = READ;
              end
            end else begin
              victim_d  = victim_sel;
              way_sel_o = victim_sel;
              if (victim_dirty) begin
                dcache2mem_req_o = 1'b1;
                dcache2mem_wr_o  = 1'b1;
                cache_wrb_req_o  = 1'b1;
                state_d          = WRITE_BACK;
              end else begin
                state_d = ALLOCATE;
              end
            end
          end
        end
        READ, WRITE: begin
          dcache2lsummu_ack_o = 1'b1;
          way_sel_o           = hit_way;
          state_d             = IDLE;
        end
        WRITE_BACK: begin
          way_sel_o = victim_q;
          if (!dmem_sel_i) begin
            state_d = IDLE;
          end else begin
            dcache2mem_req_o = 1'b1;
            dcache2mem_wr_o  = 1'b1;
            cache_wrb_req_o  = 1'b1;
            if (mem2dcache_ack_i) state_d = ALLOCATE;
          end
        end
        ALLOCATE: begin
          way_sel_o = victim_q;
          if (!dmem_sel_i) begin
            state_d = IDLE;
          end else begin
            dcache2mem_req_o = 1'b1;
            if (mem2dcache_ack_i) begin
              cache_line_wr_o = 1'b1;
              rr_inc          = 1'b1;
              state_d         = IDLE;
            end
          end
        end
        FLUSH: begin
          flush_active_o = 1'b1;
          way_sel_o      = flush_way_q;
          if (flush_line_dirty) begin
            dcache2mem_req_o = 1'b1;
            dcache2mem_wr_o  = 1'b1;
            cache_wrb_req_o  = 1'b1;
            state_d          = FLUSH_WB;
          end else if (last_line) begin
            dcache2lsummu_ack_o = 1'b1;
            evict_idx_d         = '0;
            flush_way_d         = '0;
            state_d             = IDLE;
          end else begin
            evict_idx_d = adv_idx;
            flush_way_d = adv_way;
          end
        end
        FLUSH_WB: begin
          flush_active_o   = 1'b1;
          way_sel_o        = flush_way_q;
          dcache2mem_req_o = 1'b1;
          dcache2mem_wr_o  = 1'b1;
          cache_wrb_req_o  = 1'b1;
          if (mem2dcache_ack_i) begin
            cache_line_clean_o = 1'b1;
            if (last_line) begin
              dcache2lsummu_ack_o = 1'b1;
              evict_idx_d         = '0;
              flush_way_d         = '0;
              state_d             = IDLE;
            end else begin
              evict_idx_d = adv_idx;
              flush_way_d = adv_way;
              state_d     = FLUSH;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      victim_q    <= '0;
      evict_idx_q <= '0;
      flush_way_q <= '0;
    end else begin
      state_q     <= state_d;
      victim_q    <= victim_d;
      evict_idx_q <= evict_idx_d;
      flush_way_q <= flush_way_d;
    end
  end

  // One round-robin pointer per set, bumped only when a line fill completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
    end else if (rr_inc) begin
      rr_q[req_idx_i] <= rr_q[req_idx_i] + WAY_BITS'(1);
    end
  end

endmodule

// File: tb/tb_wb_dcache_nway_controller.sv
// Testbench for wb_dcache_nway_controller: the bench plays the tag/data datapath and memory,
// keeping a set/way model of valid, dirty, tag and round-robin state to predict each access.
module tb_wb_dcache_nway_controller;

  localparam int NUM_WAYS = 4;
  localparam int NUM_SETS = 16;
  localparam int WAY_BITS = $clog2(NUM_WAYS);
  localparam int IDX_BITS = $clog2(NUM_SETS);

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                lsummu2dcache_req_i;
  logic                lsummu2dcache_wr_i;
  logic                dcache2lsummu_ack_o;
  logic                dcache_flush_i;
  logic                dmem_sel_i;
  logic [IDX_BITS-1:0] req_idx_i;
  logic [NUM_WAYS-1:0] way_hit_i;
  logic [NUM_WAYS-1:0] way_valid_i;
  logic [NUM_WAYS-1:0] way_dirty_i;
  logic [WAY_BITS-1:0] way_sel_o;
  logic                cache_wr_o;
  logic                cache_line_wr_o;
  logic                cache_line_clean_o;
  logic                cache_wrb_req_o;
  logic                flush_active_o;
  logic [IDX_BITS-1:0] evict_index_o;
  logic                dcache2mem_req_o;
  logic                dcache2mem_wr_o;
  logic                mem2dcache_ack_i;

  wb_dcache_nway_controller #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lsummu2dcache_req_i(lsummu2dcache_req_i), .lsummu2dcache_wr_i(lsummu2dcache_wr_i),
    .dcache2lsummu_ack_o(dcache2lsummu_ack_o), .dcache_flush_i(dcache_flush_i),
    .dmem_sel_i(dmem_sel_i), .req_idx_i(req_idx_i), .way_hit_i(way_hit_i),
    .way_valid_i(way_valid_i), .way_dirty_i(way_dirty_i), .way_sel_o(way_sel_o),
    .cache_wr_o(cache_wr_o), .cache_line_wr_o(cache_line_wr_o),
    .cache_line_clean_o(cache_line_clean_o), .cache_wrb_req_o(cache_wrb_req_o),
    .flush_active_o(flush_active_o), .evict_index_o(evict_index_o),
    .dcache2mem_req_o(dcache2mem_req_o), .dcache2mem_wr_o(dcache2mem_wr_o),
    .mem2dcache_ack_i(mem2dcache_ack_i)
  );

  always #5 clk_i = ~clk_i;

  bit mValid [NUM_SETS][NUM_WAYS];
  bit mDirty [NUM_SETS][NUM_WAYS];
  int mTag   [NUM_SETS][NUM_WAYS];
  int mRr    [NUM_SETS];
  int nCompared   = 0;
  int nMismatched = 0;
  int memDelay    = 0;
  bit ackNext     = 1'b0;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    nCompared++;
    if (obs != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Datapath view of set s for a lookup of tag (tag < 0 means no way can match).
  task automatic applyStimulus(input int s, input int tag);
    req_idx_i = IDX_BITS'(s);
    for (int w = 0; w < NUM_WAYS; w++) begin
      way_valid_i[w] = mValid[s][w];
      way_dirty_i[w] = mDirty[s][w];
      way_hit_i[w]   = mValid[s][w] && (tag >= 0) && (mTag[s][w] == tag);
    end
  endtask

  task automatic memResponder();
    if (mem2dcache_ack_i) memDelay = $urandom_range(0, 3);
    else if (dcache2mem_req_o) begin
      if (memDelay == 0) ackNext = 1'b1;
      else memDelay--;
    end
  endtask

  // Victim rule: lowest invalid way, otherwise the set's round-robin pointer.
  function automatic int expVictim(input int s);
    for (int w = 0; w < NUM_WAYS; w++) if (!mValid[s][w]) return w;
    return mRr[s];
  endfunction

  task automatic doAccess(input int s, input int tag, input bit wr);
    int  hitWay, vict, c, wbCnt, wbWay, fillCnt, fillWay, storeCnt, storeWay, selIssue, memSeen;
    bit  isHit, expWb, done;
    isHit = 0; hitWay = 0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (mValid[s][w] && mTag[s][w] == tag) begin isHit = 1; hitWay = w; end
    vict  = expVictim(s);
    expWb = !isHit && mValid[s][vict] && mDirty[s][vict];
    c = 0; done = 0; wbCnt = 0; wbWay = -1; fillCnt = 0; fillWay = -1;
    storeCnt = 0; storeWay = -1; selIssue = -1; memSeen = 0;
    ackNext = 0; memDelay = $urandom_range(0, 3);
    lsummu2dcache_req_i = 1'b1;
    lsummu2dcache_wr_i  = wr;
    while (!done && c < 60) begin
      applyStimulus(s, tag);
      mem2dcache_ack_i = ackNext; ackNext = 0;
      @(negedge clk_i);
      if (c == 0) selIssue = int'(way_sel_o);
      if (dcache2mem_req_o) memSeen = 1;
      if (mem2dcache_ack_i && dcache2mem_req_o && dcache2mem_wr_o && cache_wrb_req_o) begin
        wbCnt++; wbWay = int'(way_sel_o);
      end
      if (cache_line_wr_o) begin
        fillCnt++; fillWay = int'(way_sel_o);
        mValid[s][vict] = 1; mTag[s][vict] = tag; mDirty[s][vict] = 0;
        mRr[s] = (mRr[s] + 1) % NUM_WAYS;
      end
      if (cache_wr_o) begin
        storeCnt++; storeWay = int'(way_sel_o);
        mDirty[s][isHit ? hitWay : vict] = 1;
      end
      if (dcache2lsummu_ack_o) done = 1;
      memResponder();
      c++;
      @(posedge clk_i); #1;
    end
    lsummu2dcache_req_i = 1'b0;
    mem2dcache_ack_i    = 1'b0;
    checkOutput("access_done", done, 1);
    checkOutput("store_count", storeCnt, wr);
    if (isHit) begin
      checkOutput("hit_latency", c, 2);
      checkOutput("hit_way", selIssue, hitWay);
      checkOutput("hit_no_memreq", memSeen, 0);
      if (wr) checkOutput("hit_store_way", storeWay, hitWay);
    end else begin
      checkOutput("fill_count", fillCnt, 1);
      checkOutput("fill_way", fillWay, vict);
      checkOutput("wb_count", wbCnt, expWb);
      if (expWb) checkOutput("wb_way", wbWay, vict);
      if (wr) checkOutput("miss_store_way", storeWay, vict);
    end
  endtask

  task automatic doFlush(output int cycles);
    int  expDirty, wb, clean, c;
    bit  done;
    expDirty = 0;
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < NUM_WAYS; w++) if (mValid[s][w] && mDirty[s][w]) expDirty++;
    wb = 0; clean = 0; c = 0; done = 0;
    ackNext = 0; memDelay = $urandom_range(0, 3);
    dcache_flush_i = 1'b1;
    while (!done && c < 400) begin
      applyStimulus(int'(evict_index_o), -1);
      mem2dcache_ack_i = ackNext; ackNext = 0;
      @(negedge clk_i);
      if (mem2dcache_ack_i && dcache2mem_req_o && dcache2mem_wr_o && cache_wrb_req_o) wb++;
      if (cache_line_clean_o) begin
        checkOutput("flush_clean_target", int'(mDirty[evict_index_o][way_sel_o]), 1);
        mDirty[evict_index_o][way_sel_o] = 0;
        clean++;
      end
      if (dcache2lsummu_ack_o) done = 1;
      memResponder();
      c++;
      @(posedge clk_i); #1;
    end
    dcache_flush_i   = 1'b0;
    mem2dcache_ack_i = 1'b0;
    cycles = c;
    checkOutput("flush_done", done, 1);
    checkOutput("flush_wb_count", wb, expDirty);
    checkOutput("flush_clean_count", clean, expDirty);
    @(negedge clk_i);
    checkOutput("flush_single_ack", dcache2lsummu_ack_o, 0);
    checkOutput("flush_idx_cleared", evict_index_o, 0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    int cyc;
    rst_ni = 1'b0;
    lsummu2dcache_req_i = 0; lsummu2dcache_wr_i = 0; dcache_flush_i = 0;
    dmem_sel_i = 1; mem2dcache_ack_i = 0;
    req_idx_i = '0; way_hit_i = '0; way_valid_i = '0; way_dirty_i = '0;
    #2;
    checkOutput("rst_ack", dcache2lsummu_ack_o, 0);
    checkOutput("rst_memreq", dcache2mem_req_o, 0);
    checkOutput("rst_waysel", way_sel_o, 0);
    checkOutput("rst_evict_idx", evict_index_o, 0);
    #20 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Load and store hits in way 2.
    mValid[3][2] = 1; mTag[3][2] = 7;
    doAccess(3, 7, 0);
    doAccess(3, 7, 1);

    // Set 5: fill way 0 (rr 0->1), then dirty way 1 is written back and refilled, then way 2.
    for (int w = 0; w < NUM_WAYS; w++) begin mValid[5][w] = 1; mTag[5][w] = 10 + w; end
    doAccess(5, 20, 0);
    mDirty[5][1] = 1;
    doAccess(5, 21, 0);
    doAccess(5, 22, 1);

    // Set 9: invalid way 3 is preferred, then round-robin picks way 1.
    for (int w = 0; w < 3; w++) begin mValid[9][w] = 1; mTag[9][w] = w; end
    doAccess(9, 5, 0);
    doAccess(9, 6, 0);

    for (int i = 0; i < 40; i++)
      doAccess($urandom_range(0, 3), $urandom_range(0, 7), 1'($urandom_range(0, 1)));

    // dmem_sel_i drops during ALLOCATE while memory acks: request killed, no fill.
    lsummu2dcache_req_i = 1; lsummu2dcache_wr_i = 0;
    applyStimulus(12, 4);
    @(negedge clk_i); @(posedge clk_i); #1;
    applyStimulus(12, 4);
    @(negedge clk_i);
    checkOutput("alloc_memreq", dcache2mem_req_o, 1);
    checkOutput("alloc_memwr", dcache2mem_wr_o, 0);
    @(posedge clk_i); #1;
    dmem_sel_i = 0; mem2dcache_ack_i = 1;
    @(negedge clk_i);
    checkOutput("kill_memreq", dcache2mem_req_o, 0);
    checkOutput("kill_linewr", cache_line_wr_o, 0);
    @(posedge clk_i); #1;
    dmem_sel_i = 1; mem2dcache_ack_i = 0; lsummu2dcache_req_i = 0;
    @(negedge clk_i);
    checkOutput("kill_idle_memreq", dcache2mem_req_o, 0);
    @(posedge clk_i); #1;
    doAccess(12, 4, 0);

    // Flush with exactly two dirty lines, then a flush with none.
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < NUM_WAYS; w++) mDirty[s][w] = 0;
    mValid[1][0] = 1; mDirty[1][0] = 1;
    mValid[3][3] = 1; mDirty[3][3] = 1; mTag[3][3] = 50;
    doFlush(cyc);
    doFlush(cyc);
    checkOutput("flush_clean_cycles", cyc, NUM_SETS * NUM_WAYS + 1);

    // Reset asserted mid WRITE_BACK.
    for (int w = 0; w < NUM_WAYS; w++) begin mValid[6][w] = 1; mTag[6][w] = 20 + w; end
    mDirty[6][0] = 1;
    lsummu2dcache_req_i = 1; lsummu2dcache_wr_i = 0;
    applyStimulus(6, 30);
    @(negedge clk_i);
    checkOutput("wb_issue_req", dcache2mem_req_o, 1);
    checkOutput("wb_issue_wrb", cache_wrb_req_o, 1);
    @(posedge clk_i); #1;
    applyStimulus(6, 30);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("async_rst_memreq", dcache2mem_req_o, 0);
    checkOutput("async_rst_memwr", dcache2mem_wr_o, 0);
    checkOutput("async_rst_wrb", cache_wrb_req_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1; lsummu2dcache_req_i = 0;
    for (int s = 0; s < NUM_SETS; s++) mRr[s] = 0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checkOutput("post_rst_memreq", dcache2mem_req_o, 0);
    checkOutput("post_rst_ack", dcache2lsummu_ack_o, 0);
    @(posedge clk_i); #1;
    doAccess(6, 30, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
